// File: rtl/subneg_pkg.sv
// Shared definitions for the SUBNEG program loader slice.
// Holds the loader state encoding, the default memory depth and the
// address the core reserves for its display-mapped output byte.
package subneg_pkg;

  // Loader ownership states: IDLE after reset, LOAD while the pins own the
  // memory, RUN while the core owns it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ld_state_t;

  localparam int SUBNEG_DEPTH    = 32;
  // Display-mapped byte; the core owns it, the loader treats it as plain memory.
  localparam int SUBNEG_OUT_ADDR = 21;

endpackage

// File: rtl/subneg_sync_rise.sv
// Multi-flop synchroniser for one asynchronous pin.
// RISE=1 : o_sig is a one-cycle pulse on each synchronised rising edge.
// RISE=0 : o_sig is the synchronised level.
// The pulse is built only from flops (last sync stage and its delayed copy),
// so it is glitch-free.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset (chain cleared to 0)
//   i_async in  asynchronous pin
//   o_sig   out synchronised level or rising-edge pulse
module subneg_sync_rise
  import subneg_pkg::*;
#(
  parameter int STAGES = 2,
  parameter bit RISE   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sig
);

  logic [STAGES-1:0] r_sync;

  // Synchroniser shift chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  generate
    if (RISE) begin : g_rise
      logic r_prev;

      // Delayed copy of the synchronised level for edge detection.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= r_sync[STAGES-1];
        end
      end

      assign o_sig = r_sync[STAGES-1] & ~r_prev;
    end else begin : g_level
      assign o_sig = r_sync[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/subneg_prog_loader.sv
// Writer side of the SUBNEG program memory: byte-serial pin loader plus the
// DEPTH-byte memory it fills, which afterwards serves the core over req/ack.
// Optional feature macro: SUBNEG_LOAD_CSUM_EN (8-bit wrap-around sum of the
// bytes accepted in the current LOAD; without it o_ld_csum is tied to 0).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_ld_mode          async pin, 1 = loader owns memory, 0 = core owns it
//   i_ld_strobe        async pin, each rising edge writes i_ld_data
//   i_ld_data[7:0]     byte to load (stable from strobe rise to fall)
//   i_core_req/we      core request pulse / write enable
//   i_core_addr[AW-1:0], i_core_wdata[7:0]
//   o_core_rdata[7:0]  read data, held while o_core_ack=0
//   o_core_ack         one-cycle completion pulse
//   o_core_hold        1 while the core must stall (IDLE or LOAD)
//   o_ld_count[AW:0]   bytes accepted since the last LOAD entry
//   o_ld_done          1 in RUN
//   o_ld_error         sticky overflow flag
//   o_ld_csum[7:0]     load checksum
// Memory contents are deliberately not reset.
module subneg_prog_loader
  import subneg_pkg::*;
#(
  parameter int DEPTH       = SUBNEG_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_ld_mode,
  input  logic          i_ld_strobe,
  input  logic [7:0]    i_ld_data,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [7:0]    i_core_wdata,
  output logic [7:0]    o_core_rdata,
  output logic          o_core_ack,
  output logic          o_core_hold,
  output logic [AW:0]   o_ld_count,
  output logic          o_ld_done,
  output logic          o_ld_error,
  output logic [7:0]    o_ld_csum
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          WW        = $clog2(SYNC_STAGES + 1);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES);
  localparam logic [WW-1:0] WARM_ONE  = WW'(1);

  ld_state_t       r_state, w_next;
  logic            w_mode, w_strb_rise;
  logic [WW-1:0]   r_warm;
  logic [AW:0]     r_count;
  logic            r_error, r_hold, r_done;
  logic [7:0]      r_mem [DEPTH];
  logic            w_load_entry, w_ld_rise, w_ld_wr, w_ld_ovf;
  logic            w_core_go, w_core_inr;
  logic            w_mem_we;
  logic [IW-1:0]   w_mem_idx;
  logic [7:0]      w_mem_wdata;
  logic            r_req_v, r_req_we, r_req_inr;
  logic [IW-1:0]   r_req_idx;
  logic [7:0]      r_req_wdata, r_rdata;
  logic            r_ack;

  subneg_sync_rise #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_sync_mode (
    .clk(clk), .reset(reset), .i_async(i_ld_mode), .o_sig(w_mode)
  );

  subneg_sync_rise #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_strobe (
    .clk(clk), .reset(reset), .i_async(i_ld_strobe), .o_sig(w_strb_rise)
  );

  // Counts edges since reset so IDLE only decides once the mode chain holds the real pin value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm <= '0;
    end else if (r_warm != WARM_DONE) begin
      r_warm <= r_warm + WARM_ONE;
    end
  end

  // Loader state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_warm == WARM_DONE) begin
          w_next = w_mode ? LOAD : RUN;
        end else begin
          w_next = IDLE;
        end
      end
      LOAD:    w_next = w_mode ? LOAD : RUN;
      RUN:     w_next = w_mode ? LOAD : RUN;
      default: w_next = IDLE;
    endcase
  end

  assign w_load_entry = (w_next == LOAD) && (r_state != LOAD);
  assign w_ld_rise    = (r_state == LOAD) && w_strb_rise;
  assign w_ld_wr      = w_ld_rise && (r_count < DEPTH_C);
  assign w_ld_ovf     = w_ld_rise && !(r_count < DEPTH_C);
  // A request on the edge that hands the memory back to the loader is dropped.
  assign w_core_go    = (r_state == RUN) && (w_next == RUN) && i_core_req;
  assign w_core_inr   = ({1'b0, i_core_addr} < DEPTH_C);

  // Single memory write port; loader and core writes are exclusive by state.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = '0;
    w_mem_wdata = 8'd0;
    if (w_ld_wr) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_count[IW-1:0];
      w_mem_wdata = i_ld_data;
    end else if (w_core_go && i_core_we && w_core_inr) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = i_core_addr[IW-1:0];
      w_mem_wdata = i_core_wdata;
    end else begin
      w_mem_we    = 1'b0;
    end
  end

  // Program memory storage (no reset: contents survive a reset).
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // Write pointer / byte count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else if (w_load_entry) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else if (w_ld_wr) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_ld_ovf) begin
      r_error <= 1'b1;
    end
  end

`ifdef SUBNEG_LOAD_CSUM_EN
  logic [7:0] r_csum;

  // Running checksum of accepted bytes; overflow bytes never reach it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum <= 8'd0;
    end else if (w_load_entry) begin
      r_csum <= 8'd0;
    end else if (w_ld_wr) begin
      r_csum <= r_csum + i_ld_data;
    end
  end

  assign o_ld_csum = r_csum;
`else
  assign o_ld_csum = 8'd0;
`endif

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_hold <= (w_next != RUN);
      r_done <= (w_next == RUN);
    end
  end

  // Core request stage: capture the accepted request (write already issued this edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_v     <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_inr   <= 1'b0;
      r_req_idx   <= '0;
      r_req_wdata <= 8'd0;
    end else begin
      r_req_v <= w_core_go;
      if (w_core_go) begin
        r_req_we    <= i_core_we;
        r_req_inr   <= w_core_inr;
        r_req_idx   <= i_core_addr[IW-1:0];
        r_req_wdata <= i_core_wdata;
      end
    end
  end

  // Core response stage: reads see any write from the previous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      r_ack <= r_req_v;
      if (r_req_v) begin
        if (r_req_we) begin
          r_rdata <= r_req_wdata;
        end else if (r_req_inr) begin
          r_rdata <= r_mem[r_req_idx];
        end else begin
          r_rdata <= 8'd0;
        end
      end
    end
  end

  assign o_core_rdata = r_rdata;
  assign o_core_ack   = r_ack;
  assign o_core_hold  = r_hold;
  assign o_ld_count   = r_count;
  assign o_ld_done    = r_done;
  assign o_ld_error   = r_error;

endmodule

// File: tb/tb_subneg_prog_loader.sv
// Directed self-checking bench for subneg_prog_loader (DEPTH=32, AW=6 so
// that core addresses 32..63 are out of range).
module tb_subneg_prog_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_mode, ld_strobe;
  logic [7:0]    ld_data;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [7:0]    core_wdata;
  logic [7:0]    core_rdata;
  logic          core_ack, core_hold;
  logic [AW:0]   ld_count;
  logic          ld_done, ld_error;
  logic [7:0]    ld_csum;

  int n_checks = 0;
  int n_errors = 0;

  logic          ack_n, ack_n1;
  logic [7:0]    rd;

  subneg_prog_loader #(.DEPTH(DEPTH), .AW(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .i_ld_mode(ld_mode), .i_ld_strobe(ld_strobe), .i_ld_data(ld_data),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata),
    .o_core_rdata(core_rdata), .o_core_ack(core_ack), .o_core_hold(core_hold),
    .o_ld_count(ld_count), .o_ld_done(ld_done), .o_ld_error(ld_error),
    .o_ld_csum(ld_csum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    ld_data   = b;
    ld_strobe = 1'b1;
    step(4);
    ld_strobe = 1'b0;
    step(4);
  endtask

  // Request sampled on edge N; ack/rdata sampled after edge N and after edge N+1.
  task automatic core_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                         output logic o_ack_n, output logic o_ack_n1, output logic [7:0] o_rd);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    step(1);
    core_req = 1'b0; core_we = 1'b0;
    o_ack_n = core_ack;
    step(1);
    o_ack_n1 = core_ack;
    o_rd     = core_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    core_op(1'b0, a, 8'd0, ack_n, ack_n1, rd);
    chk({tag, "_ack"}, {31'd0, ack_n1}, 32'd1);
    chk(tag, {24'd0, rd}, {24'd0, exp});
  endtask

  initial begin
    reset = 1'b1; ld_mode = 1'b0; ld_strobe = 1'b0; ld_data = 8'd0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = 8'd0;
    step(3);
    // Reset state
    chk("rst_hold",  {31'd0, core_hold}, 32'd1);
    chk("rst_done",  {31'd0, ld_done},   32'd0);
    chk("rst_ack",   {31'd0, core_ack},  32'd0);
    chk("rst_rdata", {24'd0, core_rdata}, 32'd0);
    chk("rst_count", {25'd0, ld_count},  32'd0);
    chk("rst_error", {31'd0, ld_error},  32'd0);
    chk("rst_csum",  {24'd0, ld_csum},   32'd0);

    // 1. ld_mode=0 -> RUN on the third edge after reset release
    reset = 1'b0;
    step(2);
    chk("t1_hold_e2", {31'd0, core_hold}, 32'd1);
    step(1);
    chk("t1_hold_e3", {31'd0, core_hold}, 32'd0);
    chk("t1_done",    {31'd0, ld_done},   32'd1);
    chk("t1_count",   {25'd0, ld_count},  32'd0);

    // 2. Load 18,18,3 then read back
    ld_mode = 1'b1;
    step(4);
    chk("t2_hold_load", {31'd0, core_hold}, 32'd1);
    chk("t2_done_load", {31'd0, ld_done},   32'd0);
    strobe_byte(8'd18);
    strobe_byte(8'd18);
    strobe_byte(8'd3);
    chk("t2_count", {25'd0, ld_count}, 32'd3);
`ifdef SUBNEG_LOAD_CSUM_EN
    chk("t2_csum", {24'd0, ld_csum}, 32'd39);
`else
    chk("t2_csum", {24'd0, ld_csum}, 32'd0);
`endif
    ld_mode = 1'b0;
    step(4);
    chk("t2_done_run", {31'd0, ld_done}, 32'd1);
    core_op(1'b0, 6'd2, 8'd0, ack_n, ack_n1, rd);
    chk("t2_ack_early", {31'd0, ack_n},  32'd0);
    chk("t2_ack",       {31'd0, ack_n1}, 32'd1);
    chk("t2_rd2",       {24'd0, rd},     32'd3);
    step(1);
    chk("t2_ack_pulse", {31'd0, core_ack},  32'd0);
    chk("t2_rd_hold",   {24'd0, core_rdata}, 32'd3);
    rd_chk("t2_rd0", 6'd0, 8'd18);
    rd_chk("t2_rd1", 6'd1, 8'd18);

    // 4. Core writes/reads including out-of-range addresses
    core_op(1'b1, 6'd20, 8'hFF, ack_n, ack_n1, rd);
    chk("t4_wr_ack", {31'd0, ack_n1}, 32'd1);
    chk("t4_wr_rd",  {24'd0, rd},     32'd255);
    rd_chk("t4_rd20", 6'd20, 8'hFF);
    rd_chk("t4_rd40", 6'd40, 8'd0);
    core_op(1'b1, 6'd8, 8'h11, ack_n, ack_n1, rd);
    core_op(1'b1, 6'd40, 8'h55, ack_n, ack_n1, rd);
    chk("t4_oor_wr_ack", {31'd0, ack_n1}, 32'd1);
    rd_chk("t4_rd8", 6'd8, 8'h11);

    // 5. Requests while held and on the RUN->LOAD edge are dropped
    ld_mode = 1'b1;
    step(4);
    core_op(1'b1, 6'd20, 8'h00, ack_n, ack_n1, rd);
    chk("t5_hold",     {31'd0, core_hold}, 32'd1);
    chk("t5_ack_hold", {31'd0, ack_n | ack_n1}, 32'd0);
    ld_mode = 1'b0;
    step(4);
    ld_mode = 1'b1;
    step(2);
    core_op(1'b1, 6'd20, 8'h00, ack_n, ack_n1, rd);
    chk("t5_hold_edge", {31'd0, core_hold}, 32'd1);
    chk("t5_ack_edge",  {31'd0, ack_n | ack_n1}, 32'd0);
    ld_mode = 1'b0;
    step(4);
    rd_chk("t5_rd20", 6'd20, 8'hFF);

    // 3. Overflow: 33 bytes of 100+k
    ld_mode = 1'b1;
    step(4);
    for (int k = 0; k < 32; k++) strobe_byte(8'(100 + k));
    chk("t3_err_pre", {31'd0, ld_error}, 32'd0);
    strobe_byte(8'd132);
    chk("t3_count", {25'd0, ld_count}, 32'd32);
    chk("t3_error", {31'd0, ld_error}, 32'd1);
`ifdef SUBNEG_LOAD_CSUM_EN
    chk("t3_csum", {24'd0, ld_csum}, 32'd112);
`else
    chk("t3_csum", {24'd0, ld_csum}, 32'd0);
`endif
    ld_mode = 1'b0;
    step(4);
    rd_chk("t3_rd31", 6'd31, 8'd131);
    rd_chk("t3_rd0",  6'd0,  8'd100);

    // 6. Reset after 5 bytes of a load
    ld_mode = 1'b1;
    step(4);
    chk("t6_err_clr", {31'd0, ld_error}, 32'd0);
    for (int k = 0; k < 5; k++) strobe_byte(8'(8'hA0 + k));
    chk("t6_count5", {25'd0, ld_count}, 32'd5);
    reset = 1'b1;
    step(2);
    chk("t6_count", {25'd0, ld_count}, 32'd0);
    chk("t6_hold",  {31'd0, core_hold}, 32'd1);
    chk("t6_done",  {31'd0, ld_done},   32'd0);
    ld_mode = 1'b0;
    reset = 1'b0;
    step(4);
    chk("t6_run", {31'd0, ld_done}, 32'd1);
    for (int k = 0; k < 5; k++) rd_chk("t6_rd", 6'(k), 8'(8'hA0 + k));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
